// File: rtl/fixedpoint_pkg.sv
// Shared definitions for the fixed-point math library.
//   fxp_op_t : add / subtract selector carried alongside operands.
//   fxp_max  : largest representable W-bit value for the given signedness.
//   fxp_min  : smallest representable value, returned as its W-bit pattern.
package fixedpoint_pkg;

  typedef enum logic {OP_ADD, OP_SUB} fxp_op_t;

  // Returned in a 64-bit container; callers cast down to W bits.
  function automatic logic [63:0] fxp_max(input int w, input bit is_signed);
    if (is_signed) begin
      return (64'd1 << (w - 1)) - 64'd1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

  // For signed formats this is the two's-complement pattern of -2^(w-1),
  // i.e. only the sign bit set within the low w bits.
  function automatic logic [63:0] fxp_min(input int w, input bit is_signed);
    if (is_signed) begin
      return 64'd1 << (w - 1);
    end
    return 64'd0;
  endfunction

endpackage

// File: rtl/fixedpoint_saturate.sv
// Overflow detection and clamp/wrap for a (W+1)-bit intermediate value.
// Purely combinational.
//   sum_i      : (W+1)-bit result of an extended add/sub
//   op_i       : operation that produced sum_i (selects unsigned clamp end)
//   result_o   : W-bit result, clamped or wrapped
//   overflow_o : true result did not fit in W bits
module fixedpoint_saturate
  import fixedpoint_pkg::*;
#(
  parameter int W         = 8,
  parameter bit IS_SIGNED = 1'b1,
  parameter bit SATURATE  = 1'b1
) (
  input  logic [W:0]   sum_i,
  input  fxp_op_t      op_i,
  output logic [W-1:0] result_o,
  output logic         overflow_o
);

  localparam logic [W-1:0] MAX_C = W'(fxp_max(W, IS_SIGNED));
  localparam logic [W-1:0] MIN_C = W'(fxp_min(W, IS_SIGNED));

  logic [W-1:0] clamp_val;

  always_comb begin
    overflow_o = 1'b0;
    clamp_val  = MAX_C;
    if (IS_SIGNED) begin
      // The extra top bit is the true sign; disagreement with bit W-1
      // means the W-bit result has the wrong sign.
      overflow_o = sum_i[W] ^ sum_i[W-1];
      clamp_val  = sum_i[W] ? MIN_C : MAX_C;
    end else begin
      // Carry out on add, borrow on subtract; both land in bit W.
      overflow_o = sum_i[W];
      clamp_val  = (op_i == OP_SUB) ? MIN_C : MAX_C;
    end

    result_o = sum_i[W-1:0];
    if (SATURATE && overflow_o) begin
      result_o = clamp_val;
    end
  end

endmodule

// File: rtl/fixedpoint_addsub.sv
// Two-stage pipelined fixed-point adder/subtractor with valid/ready.
//   clock, reset          : single clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready is combinational)
//   op_sub                : 0 = valueOne + valueTwo, 1 = valueOne - valueTwo
//   valueOne, valueTwo    : W-bit operands, W = wholeWidth + fractionWidth
//   out_valid / out_ready : result handshake
//   result, overflow      : W-bit result and out-of-range flag
// Stage 1 registers the (W+1)-bit extended sum; stage 2 registers the
// clamped/wrapped result. Both stages share one enable so bubbles hold
// their place while stalled.
module fixedpoint_addsub
  import fixedpoint_pkg::*;
#(
  parameter int wholeWidth    = 4,
  parameter int fractionWidth = 4,
  parameter bit isSigned      = 1'b1,
  parameter bit saturate      = 1'b1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               op_sub,
  input  logic [wholeWidth+fractionWidth-1:0] valueOne,
  input  logic [wholeWidth+fractionWidth-1:0] valueTwo,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [wholeWidth+fractionWidth-1:0] result,
  output logic                               overflow
);

  localparam int W = wholeWidth + fractionWidth;

  logic         en;
  logic [W:0]   a_ext;
  logic [W:0]   b_ext;
  logic [W:0]   sum1_d;
  fxp_op_t      op_d;

  logic         s1_valid_q;
  logic [W:0]   sum1_q;
  fxp_op_t      op_q;
  logic         out_valid_q;
  logic [W-1:0] result_q;
  logic         overflow_q;

  logic [W-1:0] sat_result;
  logic         sat_overflow;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign a_ext  = isSigned ? {valueOne[W-1], valueOne} : {1'b0, valueOne};
  assign b_ext  = isSigned ? {valueTwo[W-1], valueTwo} : {1'b0, valueTwo};
  assign op_d   = op_sub ? OP_SUB : OP_ADD;
  assign sum1_d = op_sub ? (a_ext - b_ext) : (a_ext + b_ext);

  fixedpoint_saturate #(
    .W         (W),
    .IS_SIGNED (isSigned),
    .SATURATE  (saturate)
  ) u_saturate (
    .sum_i      (sum1_q),
    .op_i       (op_q),
    .result_o   (sat_result),
    .overflow_o (sat_overflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      sum1_q      <= '0;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      sum1_q      <= sum1_d;
      op_q        <= op_d;
      out_valid_q <= s1_valid_q;
      result_q    <= sat_result;
      overflow_q  <= sat_overflow;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixedpoint_addsub.sv
// Directed bench for fixedpoint_addsub in Q4.4. Four instances share the
// input stimulus and handshake; they differ only in signedness and
// saturation mode: 0 = signed/sat, 1 = signed/wrap, 2 = unsigned/wrap,
// 3 = unsigned/sat.
module tb_fixedpoint_addsub;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       op_sub = 1'b0;
  logic [7:0] value_one = 8'h00;
  logic [7:0] value_two = 8'h00;
  logic       out_ready = 1'b1;

  logic [3:0] ir_v;
  logic [3:0] ov_v;
  logic [3:0] ovf_v;
  logic [7:0] res_v [4];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fixedpoint_addsub #(.isSigned(1'b1), .saturate(1'b1)) dut_ss (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_v[0]),
    .op_sub(op_sub), .valueOne(value_one), .valueTwo(value_two),
    .out_valid(ov_v[0]), .out_ready(out_ready), .result(res_v[0]), .overflow(ovf_v[0]));

  fixedpoint_addsub #(.isSigned(1'b1), .saturate(1'b0)) dut_sw (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_v[1]),
    .op_sub(op_sub), .valueOne(value_one), .valueTwo(value_two),
    .out_valid(ov_v[1]), .out_ready(out_ready), .result(res_v[1]), .overflow(ovf_v[1]));

  fixedpoint_addsub #(.isSigned(1'b0), .saturate(1'b0)) dut_uw (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_v[2]),
    .op_sub(op_sub), .valueOne(value_one), .valueTwo(value_two),
    .out_valid(ov_v[2]), .out_ready(out_ready), .result(res_v[2]), .overflow(ovf_v[2]));

  fixedpoint_addsub #(.isSigned(1'b0), .saturate(1'b1)) dut_us (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_v[3]),
    .op_sub(op_sub), .valueOne(value_one), .valueTwo(value_two),
    .out_valid(ov_v[3]), .out_ready(out_ready), .result(res_v[3]), .overflow(ovf_v[3]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One isolated transaction; verifies two-cycle latency and all four results.
  task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] eo);
    logic [7:0] exp_r [4];
    exp_r[0] = e0; exp_r[1] = e1; exp_r[2] = e2; exp_r[3] = e3;
    in_valid  = 1'b1;
    value_one = a;
    value_two = b;
    op_sub    = sub;
    out_ready = 1'b1;
    #1;
    check({name, " in_ready"}, {4'h0, ir_v}, 8'h0F);
    tick();
    in_valid = 1'b0;
    check({name, " not_yet_valid"}, {4'h0, ov_v}, 8'h00);
    tick();
    check({name, " out_valid"}, {4'h0, ov_v}, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s result[%0d]", name, i), res_v[i], exp_r[i]);
    end
    check({name, " overflow"}, {4'h0, ovf_v}, {4'h0, eo});
    $display("txn %s: a=0x%02h b=0x%02h sub=%0d res=%02h/%02h/%02h/%02h ovf=%b",
             name, a, b, sub, res_v[0], res_v[1], res_v[2], res_v[3], ovf_v);
    tick();
  endtask

  initial begin
    logic [7:0] bp_a   [4];
    logic [7:0] bp_b   [4];
    logic       bp_sub [4];
    logic [7:0] bp_exp [4];
    logic [7:0] held;
    logic       held_valid;
    logic       accepted;
    int         tx_idx;
    int         rx_idx;
    int         stalls;

    // Reset state.
    tick();
    tick();
    check("reset out_valid", {4'h0, ov_v}, 8'h00);
    check("reset overflow", {4'h0, ovf_v}, 8'h00);
    check("reset result0", res_v[0], 8'h00);
    check("reset result3", res_v[3], 8'h00);
    reset = 1'b0;
    #1;
    check("reset in_ready", {4'h0, ir_v}, 8'h0F);

    // Order of expected results: signed/sat, signed/wrap, unsigned/wrap, unsigned/sat.
    run_one("carry_frac", 8'h18, 8'h18, 1'b0, 8'h30, 8'h30, 8'h30, 8'h30, 4'b0000);
    run_one("carry_lsb",  8'h0F, 8'h01, 1'b0, 8'h10, 8'h10, 8'h10, 8'h10, 4'b0000);
    run_one("pos_ovf",    8'h70, 8'h20, 1'b0, 8'h7F, 8'h90, 8'h90, 8'h90, 4'b0011);
    run_one("neg_ovf",    8'h80, 8'h10, 1'b1, 8'h80, 8'h70, 8'h70, 8'h70, 4'b0011);
    run_one("sub_neg",    8'h10, 8'h30, 1'b1, 8'hE0, 8'hE0, 8'hE0, 8'h00, 4'b1100);
    run_one("u_carry",    8'hF0, 8'h20, 1'b0, 8'h10, 8'h10, 8'h10, 8'hFF, 4'b1100);
    run_one("u_borrow",   8'h10, 8'h20, 1'b1, 8'hF0, 8'hF0, 8'hF0, 8'h00, 4'b1100);

    // Backpressure: 4 back-to-back pairs, out_ready low in cycles 2..4.
    bp_a[0] = 8'h01; bp_b[0] = 8'h01; bp_sub[0] = 1'b0; bp_exp[0] = 8'h02;
    bp_a[1] = 8'h02; bp_b[1] = 8'h03; bp_sub[1] = 1'b0; bp_exp[1] = 8'h05;
    bp_a[2] = 8'h10; bp_b[2] = 8'h11; bp_sub[2] = 1'b0; bp_exp[2] = 8'h21;
    bp_a[3] = 8'h20; bp_b[3] = 8'h01; bp_sub[3] = 1'b1; bp_exp[3] = 8'h1F;
    tx_idx = 0;
    rx_idx = 0;
    stalls = 0;
    held_valid = 1'b0;
    held = 8'h00;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid  = (tx_idx < 4);
      if (tx_idx < 4) begin
        value_one = bp_a[tx_idx];
        value_two = bp_b[tx_idx];
        op_sub    = bp_sub[tx_idx];
      end
      #1;
      if (held_valid) begin
        check("bp held_stable", res_v[0], held);
      end
      if (ov_v[0] && !out_ready) begin
        check("bp in_ready_low", {7'h0, ir_v[0]}, 8'h00);
        stalls++;
        held = res_v[0];
        held_valid = 1'b1;
      end else begin
        held_valid = 1'b0;
      end
      if (ov_v[0] && out_ready) begin
        if (rx_idx < 4) begin
          check($sformatf("bp result[%0d]", rx_idx), res_v[0], bp_exp[rx_idx]);
          $display("txn bp%0d: res=0x%02h", rx_idx, res_v[0]);
        end
        rx_idx++;
      end
      accepted = in_valid && ir_v[0];
      tick();
      if (accepted) tx_idx++;
    end
    in_valid = 1'b0;
    check("bp result_count", 8'(rx_idx), 8'd4);
    check("bp stall_cycles", 8'(stalls), 8'd3);

    // Reset with two transactions in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    value_one = 8'h18;
    value_two = 8'h18;
    op_sub    = 1'b0;
    tick();
    value_one = 8'h30;
    value_two = 8'h01;
    tick();
    in_valid = 1'b0;
    check("rst inflight out_valid", {7'h0, ov_v[0]}, 8'h01);
    reset = 1'b1;
    tick();
    check("rst out_valid", {4'h0, ov_v}, 8'h00);
    check("rst result", res_v[0], 8'h00);
    check("rst in_ready", {4'h0, ir_v}, 8'h0F);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst no_stale[%0d]", i), {4'h0, ov_v}, 8'h00);
    end
    $display("txn reset_midstream: done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixedpoint_addsub.md
# fixedpoint_addsub

Parametrised two-stage pipelined fixed-point adder/subtractor with a valid/ready handshake. It supports selectable signed or unsigned operands, per-transaction add/sub, saturation or wrap on overflow, and an overflow flag. Carry propagates across the whole/fraction boundary, so the result is one true W-bit sum, W = wholeWidth + fractionWidth. It sits in the fixed-point math library as the standard arithmetic stage in front of multiply/accumulate datapaths.

## Interface
- wholeWidth, default 4: integer bits, including the sign bit when signed.
- fractionWidth, default 4: fractional bits.
- isSigned, default 1: 1 means two's complement operands/result; 0 means unsigned.
- saturate, default 1: 1 clamps on overflow; 0 wraps modulo 2^W.
- clock  in  1  rising-edge clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts operands this cycle.
- op_sub  in  1  0 selects valueOne + valueTwo; 1 selects valueOne - valueTwo. Sampled with the operands.
- valueOne  in  W  operand A, fixed-point.
- valueTwo  in  W  operand B, fixed-point.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  W  sum or difference, same Q format as the inputs.
- overflow  out  1  the true result was out of range. Qualified by out_valid.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Global pipeline enable: en = !out_valid || out_ready. in_ready = en, combinational; this is the only combinational path from an input to an output.
- Stage 1, on en:
  - Extend both operands to W+1 bits: sign-extend if isSigned, else zero-extend.
  - Compute sum1 = A ± B at W+1 bits and register it.
  - s1_valid <= in_valid.
- Stage 2, on en:
  - Register the output, out_valid <= s1_valid.
  - Signed overflow: bit W of sum1 differs from bit W-1.
  - Unsigned add overflow: bit W of sum1 is set (carry out).
  - Unsigned sub overflow: bit W of sum1 is set (borrow).
  - saturate = 1: on overflow, clamp.
    - Signed positive overflow gives 2^(W-1)-1; signed negative overflow gives -2^(W-1). The direction is taken from bit W of sum1.
    - Unsigned add overflow gives 2^W-1; unsigned sub overflow gives 0.
  - saturate = 0: result = sum1[W-1:0].
  - The overflow flag is asserted in both modes.
- Bubbles (s1_valid = 0) advance with en. They do not collapse while stalled.
- While en = 0, all pipeline registers, including result and overflow, hold stable.

## Timing
- Latency: 2 cycles from input transfer to out_valid when out_ready stays high. Throughput is 1 per cycle.
- Reset values: out_valid = 0, result = 0, overflow = 0, s1_valid = 0, sum1 = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation drops all in-flight data. No result from before reset ever appears afterwards.
- With out_valid = 1 and out_ready = 0, in_ready = 0 and no input is accepted. The held result is unchanged until it is taken.
- A simultaneous output transfer and input transfer in one cycle is legal; the pipeline advances.
- op_sub, valueOne and valueTwo are don't-care when in_valid = 0.

## Structure
- Package fixedpoint_pkg holds:
  - typedef enum logic {OP_ADD, OP_SUB} fxp_op_t;
  - functions fxp_max(W, isSigned) and fxp_min(W, isSigned) for the clamp constants.
- Sub-module fixedpoint_saturate: combinational. Maps a (W+1)-bit value, the op and the mode to a W-bit result plus the overflow flag. It is reused later by the multiplier.
- Top level: stage registers, handshake logic, and one fixedpoint_saturate instance.

## Test plan
- Carry across the fraction boundary. Signed Q4.4: 0x18 + 0x18 (1.5 + 1.5) -> result 0x30, overflow 0, out_valid two cycles after acceptance.
- Signed saturation:
  - 0x70 + 0x20 -> 0x7F, overflow 1.
  - 0x80 - 0x10 -> 0x80, overflow 1.
  - 0x10 - 0x30 -> 0xE0, overflow 0.
- Unsigned wrap (isSigned = 0, saturate = 0):
  - 0xF0 + 0x20 -> 0x10, overflow 1.
  - 0x10 - 0x20 -> 0xF0, overflow 1.
- Unsigned saturation (saturate = 1):
  - 0xF0 + 0x20 -> 0xFF.
  - 0x10 - 0x20 -> 0x00.
- Backpressure:
  - Stream 4 back-to-back operand pairs with out_ready low from cycle 2 for 3 cycles.
  - Required: in_ready drops, the held result is stable, all 4 results emerge in order with none lost or duplicated.
- Reset mid-stream: assert reset with 2 transactions in flight -> next cycle out_valid = 0, result = 0, in_ready = 1, and no stale results appear afterwards.
